// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundles the handshake and datapath-control signals of the
//               multicycle controller.
//               master : controller side (drives requests and strobes)
//               slave  : datapath / memory side (drives acks, opcode, start)
//               Inputs to the controller  : start, opcode[5:0], br_cond,
//                                           imem_ack, dmem_ack
//               Outputs of the controller : imem_req, dmem_req, dmem_we,
//                                           ir_load, dec_en, reg_we, pc_en,
//                                           alu_src_imm, alu_op[3:0],
//                                           pc_src[1:0], busy, halted, err,
//                                           retired[CNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [5:0]       opcode;
  logic             br_cond;
  logic             imem_ack;
  logic             dmem_ack;

  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_load;
  logic             dec_en;
  logic             reg_we;
  logic             pc_en;
  logic             alu_src_imm;
  logic [3:0]       alu_op;
  logic [1:0]       pc_src;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, opcode, br_cond, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_load, dec_en, reg_we, pc_en,
           alu_src_imm, alu_op, pc_src, busy, halted, err, retired
  );

  modport slave (
    output start, opcode, br_cond, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_load, dec_en, reg_we, pc_en,
           alu_src_imm, alu_op, pc_src, busy, halted, err, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a multicycle processor datapath.
//               IDLE -> FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH, HALT};
//               memory handshakes are guarded by a wait-cycle timeout that
//               traps into ERR. HALT and ERR are left only through rst.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - multicycle_ctrl_if.master (handshakes and strobes)
// Parameters  : TIMEOUT - wait cycles allowed on a memory handshake (>= 1)
//               CNT_W   - width of the retired-instruction counter; must
//                         match the CNT_W of the connected interface
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input wire               clk,
  input wire               rst,
  multicycle_ctrl_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counter value seen on the last permitted wait cycle.
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [5:0]        c_OP_HALT   = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_op_q;       // class bits are consumed in EXEC only
  logic [3:0]        w_op_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_timeout;
  logic [CNT_W-1:0]  r_retired;

  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic              r_busy;
  logic              r_halted;
  logic              r_err;

  logic              w_ir_load;
  logic              w_dec_en;
  logic              w_reg_we;
  logic              w_pc_en;
  logic              w_alu_src_imm;
  logic [3:0]        w_alu_op;
  logic [1:0]        w_pc_src;

  assign w_timeout = (r_wait == c_WAIT_LAST);
  assign w_op_next = (r_state == S_EXEC) ? bus.opcode[3:0] : r_op_q;

  // --------------------------------------------------------------------------
  // Next-state decode. On the final wait cycle an ack still takes priority
  // over the timeout.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (bus.opcode[5:4])
          2'b00, 2'b01: w_next = S_WB;
          2'b10:        w_next = S_MEM;
          default:      w_next = (bus.opcode == c_OP_HALT) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack)   w_next = r_op_q[2] ? S_FETCH : S_WB;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Same-cycle strobes. These depend on the current state plus opcode,
  // br_cond and the acks; the request lines are registered separately so an
  // ack never reaches a req output combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ir_load     = 1'b0;
    w_dec_en      = 1'b0;
    w_reg_we      = 1'b0;
    w_pc_en       = 1'b0;
    w_alu_src_imm = 1'b0;
    w_alu_op      = 4'd0;
    w_pc_src      = 2'b00;
    case (r_state)
      S_FETCH:  w_ir_load = bus.imem_ack;
      S_DECODE: w_dec_en  = 1'b1;
      S_EXEC: begin
        case (bus.opcode[5:4])
          2'b00, 2'b01: begin
            w_alu_op      = bus.opcode[3:0];
            w_alu_src_imm = bus.opcode[3];
          end
          2'b11: begin
            if (!bus.opcode[3]) begin
              w_pc_en  = 1'b1;
              w_pc_src = bus.br_cond ? 2'b01 : 2'b00;
            end else if (bus.opcode != c_OP_HALT) begin
              w_pc_en  = 1'b1;
              w_pc_src = 2'b10;
            end
          end
          default: ;
        endcase
      end
      // A completed store retires here; a load retires in WB.
      S_MEM:    w_pc_en = bus.dmem_ack & r_op_q[2];
      S_WB: begin
        w_reg_we      = 1'b1;
        w_pc_en       = 1'b1;
        w_alu_op      = r_op_q;
        w_alu_src_imm = r_op_q[3];
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, wait counter, retired counter and registered outputs.
  // The registered outputs are loaded from w_next so they line up with the
  // state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_q     <= 4'd0;
      r_wait     <= '0;
      r_retired  <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_op_q  <= w_op_next;

      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_wait <= r_wait + 1'b1;

      if (w_pc_en)
        r_retired <= r_retired + 1'b1;

      r_imem_req <= (w_next == S_FETCH);
      r_dmem_req <= (w_next == S_MEM);
      r_dmem_we  <= (w_next == S_MEM) & w_op_next[2];
      r_busy     <= (w_next == S_FETCH) || (w_next == S_DECODE) ||
                    (w_next == S_EXEC)  || (w_next == S_MEM)    ||
                    (w_next == S_WB);
      r_halted   <= (w_next == S_HALT);
      r_err      <= (w_next == S_ERR);
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.dmem_req    = r_dmem_req;
  assign bus.dmem_we     = r_dmem_we;
  assign bus.ir_load     = w_ir_load;
  assign bus.dec_en      = w_dec_en;
  assign bus.reg_we      = w_reg_we;
  assign bus.pc_en       = w_pc_en;
  assign bus.alu_src_imm = w_alu_src_imm;
  assign bus.alu_op      = w_alu_op;
  assign bus.pc_src      = w_pc_src;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.err         = r_err;
  assign bus.retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed scoreboard bench for multicycle_ctrl. Stimulus
//               tasks push the hand-derived output vector expected for each
//               checked cycle; a negedge monitor pops and compares whenever
//               the DUT raises a strobe or the stimulus marks a probe cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_load;
    logic       dec_en;
    logic       reg_we;
    logic       pc_en;
    logic       alu_src_imm;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       busy;
    logic       halted;
    logic       err;
    logic [3:0] retired;
  } obs_t;

  logic clk;
  logic rst;
  logic probe;

  multicycle_ctrl_if #(.CNT_W(4)) bus ();

  multicycle_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t       exp_q[$];
  string      name_q[$];
  int         n_cmp;
  int         n_bad;
  logic [3:0] exp_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t a;
    a.imem_req    = bus.imem_req;
    a.dmem_req    = bus.dmem_req;
    a.dmem_we     = bus.dmem_we;
    a.ir_load     = bus.ir_load;
    a.dec_en      = bus.dec_en;
    a.reg_we      = bus.reg_we;
    a.pc_en       = bus.pc_en;
    a.alu_src_imm = bus.alu_src_imm;
    a.alu_op      = bus.alu_op;
    a.pc_src      = bus.pc_src;
    a.busy        = bus.busy;
    a.halted      = bus.halted;
    a.err         = bus.err;
    a.retired     = bus.retired;
    return a;
  endfunction

  // Monitor: every strobe cycle and every probe cycle consumes one entry.
  always @(negedge clk) begin
    obs_t  act;
    obs_t  e;
    string nm;
    if (bus.ir_load || bus.dec_en || bus.reg_we || bus.pc_en || probe) begin
      act = sample();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %h required no output", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %h required %h (t=%0t)", nm, act, e, $time);
        end
      end
    end
  end

  // Idle-looking vector carrying the current expected retired count.
  function automatic obs_t bz();
    obs_t o;
    o = '0;
    o.retired = exp_ret;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic do_reset();
    obs_t o;
    rst     = 1'b1;
    exp_ret = 4'd0;
    step("reset", '0);
    rst = 1'b0;
    o = bz();
    step("idle_after_reset", o);
    step("idle_hold", o);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step("idle_start", bz());
    bus.start = 1'b0;
  endtask

  task automatic do_fetch(input int waits);
    obs_t o;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      o = bz(); o.busy = 1'b1; o.imem_req = 1'b1;
      step("fetch_wait", o);
    end
    bus.imem_ack = 1'b1;
    o = bz(); o.busy = 1'b1; o.imem_req = 1'b1; o.ir_load = 1'b1;
    step("fetch_ack", o);
    bus.imem_ack = 1'b0;
    bus.opcode   = 6'b111111;   // not yet valid; must be ignored
    o = bz(); o.busy = 1'b1; o.dec_en = 1'b1;
    step("decode", o);
  endtask

  task automatic do_alu(input logic [5:0] op);
    obs_t o;
    bus.opcode = op;
    o = bz(); o.busy = 1'b1; o.alu_op = op[3:0]; o.alu_src_imm = op[3];
    step("exec_alu", o);
    bus.opcode = ~op;           // WB must use the captured opcode
    o = bz(); o.busy = 1'b1; o.reg_we = 1'b1; o.pc_en = 1'b1;
    o.alu_op = op[3:0]; o.alu_src_imm = op[3];
    step("wb_alu", o);
    exp_ret++;
    bus.opcode = 6'd0;
  endtask

  task automatic do_mem(input logic [5:0] op, input int waits);
    obs_t o;
    bus.opcode = op;
    o = bz(); o.busy = 1'b1;
    step("exec_mem", o);
    bus.opcode   = ~op;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      o = bz(); o.busy = 1'b1; o.dmem_req = 1'b1; o.dmem_we = op[2];
      step("mem_wait", o);
    end
    bus.dmem_ack = 1'b1;
    o = bz(); o.busy = 1'b1; o.dmem_req = 1'b1; o.dmem_we = op[2];
    o.pc_en = op[2];
    step("mem_ack", o);
    bus.dmem_ack = 1'b0;
    if (op[2]) begin
      exp_ret++;
    end else begin
      o = bz(); o.busy = 1'b1; o.reg_we = 1'b1; o.pc_en = 1'b1;
      o.alu_op = op[3:0]; o.alu_src_imm = op[3];
      step("wb_load", o);
      exp_ret++;
    end
    bus.opcode = 6'd0;
  endtask

  task automatic do_pc(input logic [5:0] op, input logic bc, input logic [1:0] src);
    obs_t o;
    bus.opcode  = op;
    bus.br_cond = bc;
    o = bz(); o.busy = 1'b1; o.pc_en = 1'b1; o.pc_src = src;
    step("exec_pc", o);
    exp_ret++;
    bus.br_cond = 1'b0;
    bus.opcode  = 6'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    n_cmp        = 0;
    n_bad        = 0;
    exp_ret      = 4'd0;
    probe        = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.opcode   = 6'd0;
    bus.br_cond  = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    tick();
    do_reset();

    // ALU immediate op; first wait probe is FETCH, 5 cycles after start.
    do_start();
    do_fetch(0);
    do_alu(6'b001010);
    do_fetch(1);
    do_mem(6'b100000, 3);       // load, ack after 3 wait cycles
    do_fetch(0);
    do_mem(6'b100100, 1);       // store
    do_fetch(0);
    do_pc(6'b110000, 1'b1, 2'b01);
    do_fetch(0);
    do_pc(6'b110000, 1'b0, 2'b00);
    do_fetch(0);
    do_pc(6'b111000, 1'b0, 2'b10);
    do_fetch(0);
    do_alu(6'b010111);
    do_fetch(14);               // ack on the 15th FETCH cycle
    do_alu(6'b000011);

    // 8 retired so far; 9 more jumps brings the 4-bit counter to 17 mod 16.
    for (int i = 0; i < 9; i++) begin
      do_fetch(0);
      do_pc((i % 2 == 0) ? 6'b111000 : 6'b111010, 1'b1, 2'b10);
    end
    do_fetch(1);

    // Halt: no retire, sticky against start.
    bus.opcode = 6'b111111;
    o = bz(); o.busy = 1'b1;
    step("exec_halt", o);
    bus.opcode = 6'd0;
    bus.start  = 1'b1;
    o = bz(); o.halted = 1'b1;
    step("halt", o);
    step("halt_hold", o);
    bus.start = 1'b0;
    do_reset();

    // Reset in the middle of a stalled load.
    do_start();
    do_fetch(0);
    bus.opcode = 6'b100000;
    o = bz(); o.busy = 1'b1;
    step("exec_mem", o);
    bus.opcode = 6'd0;
    o = bz(); o.busy = 1'b1; o.dmem_req = 1'b1;
    step("mem_wait", o);
    rst     = 1'b1;             // asserted between clock edges
    exp_ret = 4'd0;
    step("rst_mid_mem", '0);
    rst = 1'b0;
    step("idle_after_mid_rst", bz());

    // Timeout: 15 unacknowledged FETCH cycles, then ERR, sticky.
    do_start();
    for (int i = 0; i < 15; i++) begin
      o = bz(); o.busy = 1'b1; o.imem_req = 1'b1;
      step("timeout_wait", o);
    end
    o = bz(); o.err = 1'b1;
    step("err", o);
    bus.imem_ack = 1'b1;
    bus.start    = 1'b1;
    step("err_hold", o);
    step("err_hold", o);
    bus.imem_ack = 1'b0;
    bus.start    = 1'b0;
    do_reset();

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum number of wait cycles on a memory handshake before an error is raised.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: begin execution from IDLE.
REQ-006 SHALL have port opcode, input, 6 bits: decoded opcode from the instruction decoder. Bits [5:4] are the class, bit [3] is the imm/form flag, bits [3:0] are the ALU function.
REQ-007 SHALL have port br_cond, input, 1 bit: datapath branch-condition result.
REQ-008 SHALL have ports imem_ack and dmem_ack, inputs, 1 bit each: memory acknowledges.
REQ-009 SHALL have ports imem_req, dmem_req and dmem_we, outputs, 1 bit each: memory requests and store strobe.
REQ-010 SHALL have ports ir_load, dec_en, reg_we, pc_en and alu_src_imm, outputs, 1 bit each: datapath strobes.
REQ-011 SHALL have port alu_op, output, 4 bits; and port pc_src, output, 2 bits (00 = +1, 01 = branch imm10, 10 = jump imm20).
REQ-012 SHALL have ports busy, halted and err, outputs, 1 bit each; and port retired, output, CNT_W bits.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-014 IDLE: when start=1, SHALL go to FETCH next cycle; start SHALL be ignored in every other state.
REQ-015 FETCH: SHALL hold imem_req=1 until imem_ack=1. On ack, SHALL pulse ir_load=1 in that cycle and go to DECODE.
REQ-016 DECODE: SHALL assert dec_en=1 for exactly one cycle, then go to EXEC. The opcode input is valid from the first EXEC cycle.
REQ-017 EXEC: SHALL sample opcode into internal op_q at the EXEC->next edge. Outputs in EXEC SHALL be derived combinationally from opcode.
REQ-018 Class 00/01 (ALU): alu_op=opcode[3:0] and alu_src_imm=opcode[3]; next state WB.
REQ-019 Class 10 (memory): next state MEM. Loads are opcode[2]=0; stores are opcode[2]=1.
REQ-020 Class 11, opcode[3]=0 (conditional branch): pc_en=1 in EXEC; pc_src=01 if br_cond=1, else 00; next state FETCH.
REQ-021 Class 11, opcode[3]=1, opcode≠6'b111111 (jump): pc_en=1, pc_src=10; next state FETCH.
REQ-022 Opcode 6'b111111: next state HALT; pc_en SHALL stay 0.
REQ-023 MEM: dmem_req=1 and dmem_we=op_q[2] SHALL be held until dmem_ack. On ack, a load SHALL go to WB; a store SHALL assert pc_en=1 with pc_src=00 and go to FETCH.
REQ-024 WB: reg_we=1 and pc_en=1 with pc_src=00 for exactly one cycle; alu_op/alu_src_imm SHALL reflect op_q; next state FETCH.
REQ-025 Outside the cases above, every strobe SHALL be 0, pc_src=00, alu_op=0, alu_src_imm=0.
REQ-026 Wait counter: SHALL count cycles spent in FETCH or MEM without an ack, and clear on any state change.
REQ-027 When the wait counter reaches TIMEOUT with no ack, SHALL go to ERR instead. An ack arriving on that same cycle SHALL win: normal transition, no error.
REQ-028 ERR: err=1 and all strobes 0; SHALL leave only via rst.
REQ-029 HALT: halted=1 and all strobes 0; SHALL leave only via rst.
REQ-030 busy SHALL be 1 in FETCH, DECODE, EXEC, MEM and WB, and 0 otherwise.
REQ-031 retired SHALL increment by 1 on every cycle pc_en=1, wrapping modulo 2^CNT_W.
REQ-032 Every output change SHALL follow from registered state plus current inputs; there SHALL be no combinational path from imem_ack or dmem_ack to the req outputs of the same state.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, op_q=0, wait counter 0, retired=0, and all outputs 0, including mid-FETCH/MEM with req asserted (req drops without waiting for ack).
REQ-034 After rst deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-035 ALU op: reset, start, imem_ack on the 1st FETCH cycle, opcode=6'b001010 -> ir_load, dec_en, EXEC with alu_op=1010 and alu_src_imm=1, WB with reg_we=1 and pc_en=1, retired=1, back in FETCH 5 cycles after start.
REQ-036 Load with delayed ack: opcode=6'b100000, dmem_ack after 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then WB reg_we=1. Store, opcode=6'b100100 -> dmem_we=1, no reg_we, pc_en on the ack cycle.
REQ-037 Branch and jump: opcode=6'b110000 with br_cond=1 -> pc_src=01; with br_cond=0 -> pc_src=00. Opcode=6'b111000 -> pc_src=10; each asserts pc_en for 1 cycle.
REQ-038 Timeout: imem_ack held 0 -> ERR after TIMEOUT=15 wait cycles, err=1, imem_req=0. Ack exactly on the 15th cycle -> no error.
REQ-039 Halt and reset: opcode=6'b111111 -> halted=1, busy=0, retired unchanged. rst pulse mid-MEM -> dmem_req=0 asynchronously, retired=0, IDLE.
REQ-040 Counter wrap: with CNT_W=4, retire 17 instructions -> retired=1.
